// File: rtl/line_sensor_pkg.sv
// rtl/line_sensor_pkg.sv - shared constants, state and sensor-select types for the line sensor ADC reader
package line_sensor_pkg;

    localparam int ADC_BITS       = 12;
    localparam int FRAME_BITS     = 16;
    localparam int ADDR_FIRST_BIT = 2;
    localparam int DATA_FIRST_BIT = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP
    } state_t;

    typedef enum logic [1:0] {
        SENS_L,
        SENS_C,
        SENS_R
    } sensor_t;

    function automatic sensor_t sens_next(input sensor_t s);
        sensor_t n;
        case (s)
            SENS_L:  n = SENS_C;
            SENS_C:  n = SENS_R;
            default: n = SENS_L;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// rtl/adc_sclk_gen.sv - half-period counter producing the ADC serial clock level and edge strobes
module adc_sclk_gen #(
    parameter int HALF = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    input  logic i_hold,
    output logic o_sck,
    output logic o_rise,
    output logic o_fall,
    output logic o_wrap
);

    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_sck;
    logic             w_wrap;

    assign w_wrap = i_active && (r_cnt == CNT_MAX);

    // i_hold keeps sck high across a wrap so SETUP-like phases can be stretched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_sck <= 1'b1;
        end else if (!i_active) begin
            r_cnt <= '0;
            r_sck <= 1'b1;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_sck <= i_hold ? 1'b1 : ~r_sck;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_sck  = r_sck;
    assign o_wrap = w_wrap;
    assign o_rise = w_wrap && !i_hold && !r_sck;
    assign o_fall = w_wrap && !i_hold && r_sck;

endmodule

// File: rtl/line_sensor_adc_reader.sv
// rtl/line_sensor_adc_reader.sv - SPI front-end cycling L/C/R channels of a 12-bit ADC into registered samples
module line_sensor_adc_reader
    import line_sensor_pkg::*;
#(
    parameter int CLK_DIV = 20,
    parameter int CH_L    = 5,
    parameter int CH_C    = 6,
    parameter int CH_R    = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                adc_dout,
    output logic                adc_cs_n,
    output logic                adc_sck,
    output logic                adc_din,
    output logic [ADC_BITS-1:0] l_data,
    output logic [ADC_BITS-1:0] c_data,
    output logic [ADC_BITS-1:0] r_data,
    output logic                sample_valid
);

    localparam int HALF = CLK_DIV / 2;
    localparam logic [2:0] ADDR_L = 3'(CH_L);
    localparam logic [2:0] ADDR_C = 3'(CH_C);
    localparam logic [2:0] ADDR_R = 3'(CH_R);
    localparam logic [3:0] K_ADDR = 4'(ADDR_FIRST_BIT);
    localparam logic [3:0] K_DATA = 4'(DATA_FIRST_BIT);
    localparam logic [3:0] K_LAST = 4'(FRAME_BITS - 1);

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_bit;
    logic                r_din;
    logic [ADC_BITS-1:0] r_shift;
    sensor_t             r_seq;
    sensor_t             r_prev;
    logic                r_prime;
    logic [ADC_BITS-1:0] r_l;
    logic [ADC_BITS-1:0] r_c;
    logic [ADC_BITS-1:0] r_r;
    logic                r_valid;

    logic       w_sck;
    logic       w_rise;
    logic       w_fall;
    logic       w_wrap;
    logic       w_active;
    logic       w_hold;
    logic       w_last_high;
    logic       w_gap_entry;
    logic [3:0] w_k_next;
    logic [2:0] w_addr;
    logic       w_din_next;

    // The final high half of bit 15 runs straight into GAP without another sck fall
    assign w_last_high = (r_state == SHIFT) && (r_bit == K_LAST) && w_sck;
    assign w_active    = (r_state != IDLE);
    assign w_hold      = (r_state == GAP) || w_last_high;
    assign w_gap_entry = w_last_high && w_wrap;

    adc_sclk_gen #(
        .HALF (HALF)
    ) u_sclk (
        .clk      (clk),
        .rst      (reset),
        .i_active (w_active),
        .i_hold   (w_hold),
        .o_sck    (w_sck),
        .o_rise   (w_rise),
        .o_fall   (w_fall),
        .o_wrap   (w_wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (enable) w_next = SETUP;
            SETUP:   if (w_fall) w_next = SHIFT;
            SHIFT:   if (w_gap_entry) w_next = GAP;
            GAP:     if (w_wrap) w_next = enable ? SETUP : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_addr = ADDR_R;
        case (r_seq)
            SENS_L:  w_addr = ADDR_L;
            SENS_C:  w_addr = ADDR_C;
            default: w_addr = ADDR_R;
        endcase
    end

    always_comb begin
        w_k_next   = (r_state == SETUP) ? 4'd0 : r_bit + 4'd1;
        w_din_next = 1'b0;
        if (w_k_next == K_ADDR) begin
            w_din_next = w_addr[2];
        end else if (w_k_next == K_ADDR + 4'd1) begin
            w_din_next = w_addr[1];
        end else if (w_k_next == K_ADDR + 4'd2) begin
            w_din_next = w_addr[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit   <= 4'd0;
            r_din   <= 1'b0;
            r_shift <= '0;
            r_seq   <= SENS_L;
            r_prev  <= SENS_L;
            r_prime <= 1'b1;
            r_l     <= '0;
            r_c     <= '0;
            r_r     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (r_state == IDLE && enable) begin
                r_seq   <= SENS_L;
                r_prime <= 1'b1;
            end
            if (w_fall) begin
                r_bit <= w_k_next;
                r_din <= w_din_next;
            end
            if (w_rise && r_state == SHIFT && r_bit >= K_DATA) begin
                r_shift <= {r_shift[ADC_BITS-2:0], adc_dout};
            end
            // Data in this frame belongs to the channel addressed by the previous frame
            if (w_gap_entry) begin
                if (!r_prime) begin
                    case (r_prev)
                        SENS_L:  r_l <= r_shift;
                        SENS_C:  r_c <= r_shift;
                        default: begin
                            r_r     <= r_shift;
                            r_valid <= 1'b1;
                        end
                    endcase
                end
                r_prev  <= r_seq;
                r_seq   <= sens_next(r_seq);
                r_prime <= 1'b0;
            end
        end
    end

    assign adc_cs_n     = (r_state == IDLE) || (r_state == GAP);
    assign adc_sck      = w_sck;
    assign adc_din      = r_din;
    assign l_data       = r_l;
    assign c_data       = r_c;
    assign r_data       = r_r;
    assign sample_valid = r_valid;

endmodule

// File: doc/line_sensor_adc_reader.md
Name: line_sensor_adc_reader

Overview:
- Serial front-end for the 3-channel line sensor array on the ADC128S022-class 8-channel, 12-bit SPI ADC.
- Generates SCLK, CS_N and the DIN channel address.
- Shifts in DOUT and rotates through the left, centre and right channels.
- Publishes registered 12-bit L/C/R samples plus a set-complete strobe to the line-follower decision/PWM stage directly downstream.

Parameters:
- CLK_DIV, 20: clk cycles per SCLK period (50 MHz -> 2.5 MHz). Must be even and >= 4; half-period HALF = CLK_DIV/2.
- CH_L, 5: ADC channel for the left sensor.
- CH_C, 6: ADC channel for the centre sensor.
- CH_R, 7: ADC channel for the right sensor.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run conversions while high.
- adc_dout  in  1  ADC serial data out.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_sck  out  1  ADC serial clock.
- adc_din  out  1  ADC address input.
- l_data  out  12  latest left sample.
- c_data  out  12  latest centre sample.
- r_data  out  12  latest right sample.
- sample_valid  out  1  one-clk pulse when a full L,C,R set has been refreshed.

Behaviour:
- Clock and reset:
  - One clock domain. Reset is asynchronous and active-high.
  - Reset values: adc_cs_n=1, adc_sck=1, adc_din=0, l/c/r_data=0, sample_valid=0. FSM=IDLE, sequence counter=0.
- States:
  - IDLE: cs_n=1, sck=1. Leaves to SETUP on the first clk edge with enable=1.
  - SETUP: cs_n=0, sck=1 for HALF clks.
  - SHIFT: 16 SCLK periods, each HALF clks low then HALF clks high.
  - GAP: cs_n=1, sck=1 for HALF clks. Then SETUP if enable=1, else IDLE.
- Frame timing:
  - Frame period = 17*CLK_DIV clks (340 at default), measured from cs_n fall to the next cs_n fall.
  - Bit index k=0..15 counts SCLK falling edges within SHIFT.
- Address (DIN):
  - Changes only on the sck falling edge.
  - At k=2,3,4 adc_din = ADD2,ADD1,ADD0 of this frame's target channel; 0 at all other times.
- Data (DOUT):
  - Sampled on the clk edge that raises sck.
  - Bits at k=0..3 are ignored (leading zeros). Bits at k=4..15 form D11..D0, MSB first, into a 12-bit shift register.
- Channel pipeline:
  - Frame n addresses target[n mod 3] in the order CH_L, CH_C, CH_R.
  - Data shifted in during frame n belongs to the channel addressed in frame n-1.
  - Frame 0 after reset or after leaving IDLE is a priming frame; its data is discarded and no register updates.
- Output update:
  - On entry to GAP the completed word goes to l_data, c_data or r_data per the previous frame's target.
  - sample_valid pulses for exactly one clk on the GAP entry that writes r_data.
  - The first sample_valid comes at the end of frame 3. Thereafter it repeats every 3 frames (1020 clks).
- Data stability: l/c/r_data hold their value between updates and never show partial shifts.
- enable deasserted mid-frame: the current frame (including GAP) completes and outputs update normally, then the FSM enters IDLE. Re-enable restarts with a priming frame and the sequence counter reset to 0; held data stays until overwritten.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronously). No partial word is ever written.
- Counters:
  - Half-period counter is clog2(HALF) bits wide and wraps to 0 at HALF-1.
  - Bit counter is 4 bits, 0..15.
  - Sequence counter is 2 bits and counts 0,1,2,0…. The priming state is a separate flag.

Decomposition:
- line_sensor_pkg holds:
  - ADC_BITS=12, FRAME_BITS=16, ADDR_FIRST_BIT=2, DATA_FIRST_BIT=4.
  - The FSM state enum {IDLE, SETUP, SHIFT, GAP}.
  - The sensor-select enum {SENS_L, SENS_C, SENS_R}.
- One sub-module, adc_sclk_gen: a half-period counter giving sck level plus one-clk sck_rise and sck_fall strobes, gated by an active input.

Test Plan:
- ADC model returns ch5=12'hA5C, ch6=12'h3F0, ch7=12'hFFF. Reset then enable=1 -> first sample_valid 4*340 clks after the first cs_n fall, with l=A5C, c=3F0, r=FFF. Exactly one pulse per 1020 clks afterwards.
- Decode adc_din at k=2..4 over six frames -> addresses 101,110,111,101,110,111. adc_din=0 elsewhere and changes only on sck falling edges.
- Measure timing -> adc_sck period 20 clks with 50% duty, 16 falling edges per cs_n-low window, cs_n high for 10 clks between frames.
- Drop enable at k=7 of frame 5 -> frame completes, c_data updated, no further cs_n fall. Re-enable -> priming frame first, next valid 4 frames later.
- Assert reset at k=9 -> same clk cs_n=1, sck=1, outputs 0. Model value 12'h800 for ch5 never appears in l_data before a full post-reset sequence.
- Model drives 4'hF on the leading bits with data 12'h001 -> stored value is 12'h001, leading bits ignored.
